// File: rtl/keypad_key_fifo.sv
// Key-event FIFO between the keypad scan driver and the MCU: edge-detected capture,
// show-ahead head data, level interrupt while keys are pending, sticky overflow flag.
module keypad_key_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] KEY_DATA,
    input  logic             KEY_VALID,
    input  logic             RD_EN,
    input  logic             INT_EN,
    input  logic             CLR_OVF,
    output logic [WIDTH-1:0] DATA,
    output logic             INTR,
    output logic             EMPTY,
    output logic             FULL,
    output logic [PW:0]      COUNT,
    output logic             OVERFLOW
);

    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic [PW:0]      count_nxt_s;
    logic             kv_q_r;
    logic             ovf_r;
    logic             intr_r;
    logic             push_s;
    logic             pop_ok_s;
    logic             push_ok_s;
    logic             drop_s;
    logic             empty_s;
    logic             full_s;

    assign push_s  = KEY_VALID & ~kv_q_r;
    assign empty_s = (count_r == {(PW+1){1'b0}});
    assign full_s  = (count_r == DEPTH_C);

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign pop_ok_s  = RD_EN & ~empty_s;
    assign push_ok_s = push_s & (~full_s | pop_ok_s);
    assign drop_s    = push_s & full_s & ~pop_ok_s;

    // Next occupancy from accepted push/pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + (PW+1)'(1'b1);
            2'b01:   count_nxt_s = count_r - (PW+1)'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Control state: pointers, occupancy, edge detect, flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
            kv_q_r   <= 1'b0;
            ovf_r    <= 1'b0;
            intr_r   <= 1'b0;
        end else begin
            kv_q_r  <= KEY_VALID;
            count_r <= count_nxt_s;
            intr_r  <= INT_EN & (count_nxt_s != {(PW+1){1'b0}});
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (CLR_OVF) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= KEY_DATA;
        end
    end

    assign DATA     = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
    assign EMPTY    = empty_s;
    assign FULL     = full_s;
    assign COUNT    = count_r;
    assign OVERFLOW = ovf_r;
    assign INTR     = intr_r;

endmodule

// File: tb/tb_keypad_key_fifo.sv
// Directed self-checking bench for keypad_key_fifo (WIDTH=8, DEPTH=8).
module tb_keypad_key_fifo;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] KEY_DATA;
    logic       KEY_VALID;
    logic       RD_EN;
    logic       INT_EN;
    logic       CLR_OVF;
    logic [7:0] DATA;
    logic       INTR;
    logic       EMPTY;
    logic       FULL;
    logic [3:0] COUNT;
    logic       OVERFLOW;

    int passed = 0;
    int total  = 0;

    keypad_key_fifo #(.WIDTH(8), .DEPTH(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .KEY_DATA(KEY_DATA), .KEY_VALID(KEY_VALID),
        .RD_EN(RD_EN), .INT_EN(INT_EN), .CLR_OVF(CLR_OVF), .DATA(DATA),
        .INTR(INTR), .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // Inputs change on the falling edge; outputs are sampled on the falling edge.
    task automatic push_key(input logic [7:0] d);
        KEY_DATA = d; KEY_VALID = 1'b1;
        @(negedge CLK);
        KEY_VALID = 1'b0;
        @(negedge CLK);
    endtask

    task automatic pop_key();
        RD_EN = 1'b1;
        @(negedge CLK);
        RD_EN = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; KEY_DATA = 8'h00; KEY_VALID = 1'b0; RD_EN = 1'b0;
        INT_EN = 1'b1; CLR_OVF = 1'b0;
        repeat (2) @(negedge CLK);
        total++; if ({EMPTY, FULL, INTR, OVERFLOW} !== 4'b1000) $display("FAIL reset_flags got=%b exp=1000", {EMPTY, FULL, INTR, OVERFLOW}); else passed++;
        total++; if ({DATA, COUNT} !== 12'h000) $display("FAIL reset_data_count got=%h/%h exp=00/0", DATA, COUNT); else passed++;
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single_key();
        KEY_DATA = 8'h31; KEY_VALID = 1'b1;
        @(negedge CLK);
        KEY_VALID = 1'b0;
        total++; if (EMPTY !== 1'b0 || COUNT !== 4'd1) $display("FAIL single_push empty=%b count=%0d exp=0/1", EMPTY, COUNT); else passed++;
        total++; if (DATA !== 8'h31 || INTR !== 1'b1) $display("FAIL single_data data=%h intr=%b exp=31/1", DATA, INTR); else passed++;
        pop_key();
        total++; if (EMPTY !== 1'b1 || DATA !== 8'h00 || INTR !== 1'b0) $display("FAIL single_pop empty=%b data=%h intr=%b exp=1/00/0", EMPTY, DATA, INTR); else passed++;
    endtask

    task automatic test_held_valid();
        KEY_DATA = 8'h05; KEY_VALID = 1'b1;
        repeat (20) @(negedge CLK);
        KEY_VALID = 1'b0;
        @(negedge CLK);
        total++; if (COUNT !== 4'd1 || DATA !== 8'h05) $display("FAIL held_valid count=%0d data=%h exp=1/05", COUNT, DATA); else passed++;
        pop_key();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 8; i++) push_key(8'(i));
        push_key(8'h09);
        total++; if (FULL !== 1'b1 || COUNT !== 4'd8 || OVERFLOW !== 1'b1) $display("FAIL ovf_flags full=%b count=%0d ovf=%b exp=1/8/1", FULL, COUNT, OVERFLOW); else passed++;
        for (int i = 1; i <= 8; i++) begin
            total++; if (DATA !== 8'(i)) $display("FAIL ovf_read%0d got=%h exp=%h", i, DATA, 8'(i)); else passed++;
            pop_key();
        end
        total++; if (EMPTY !== 1'b1 || DATA !== 8'h00) $display("FAIL ovf_drained empty=%b data=%h exp=1/00", EMPTY, DATA); else passed++;
        CLR_OVF = 1'b1;
        @(negedge CLK);
        CLR_OVF = 1'b0;
        total++; if (OVERFLOW !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", OVERFLOW); else passed++;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_q [8];
        for (int i = 1; i <= 8; i++) push_key(8'(i));
        KEY_DATA = 8'hAA; KEY_VALID = 1'b1; RD_EN = 1'b1;
        @(negedge CLK);
        KEY_VALID = 1'b0; RD_EN = 1'b0;
        total++; if (COUNT !== 4'd8 || OVERFLOW !== 1'b0 || DATA !== 8'h02) $display("FAIL full_pushpop count=%0d ovf=%b data=%h exp=8/0/02", COUNT, OVERFLOW, DATA); else passed++;
        @(negedge CLK);
        // Drop and clear in the same cycle: the drop must win.
        KEY_DATA = 8'h55; KEY_VALID = 1'b1; CLR_OVF = 1'b1;
        @(negedge CLK);
        KEY_VALID = 1'b0; CLR_OVF = 1'b0;
        total++; if (OVERFLOW !== 1'b1 || COUNT !== 4'd8) $display("FAIL set_wins ovf=%b count=%0d exp=1/8", OVERFLOW, COUNT); else passed++;
        CLR_OVF = 1'b1;
        @(negedge CLK);
        CLR_OVF = 1'b0;
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};
        for (int i = 0; i < 8; i++) begin
            total++; if (DATA !== exp_q[i]) $display("FAIL full_read%0d got=%h exp=%h", i, DATA, exp_q[i]); else passed++;
            pop_key();
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 12; i++) begin
            push_key(8'h10 + 8'(i));
            total++; if (COUNT !== 4'd1 || DATA !== 8'h10 + 8'(i)) $display("FAIL wrap%0d count=%0d data=%h exp=1/%h", i, COUNT, DATA, 8'h10 + 8'(i)); else passed++;
            pop_key();
        end
        pop_key();
        total++; if (COUNT !== 4'd0 || OVERFLOW !== 1'b0 || EMPTY !== 1'b1) $display("FAIL empty_read count=%0d ovf=%b empty=%b exp=0/0/1", COUNT, OVERFLOW, EMPTY); else passed++;
    endtask

    task automatic test_async_reset();
        push_key(8'hA1); push_key(8'hA2); push_key(8'hA3);
        total++; if (COUNT !== 4'd3 || INTR !== 1'b1) $display("FAIL pre_reset count=%0d intr=%b exp=3/1", COUNT, INTR); else passed++;
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        total++; if (EMPTY !== 1'b1 || COUNT !== 4'd0 || INTR !== 1'b0 || DATA !== 8'h00) $display("FAIL async_reset empty=%b count=%0d intr=%b data=%h exp=1/0/0/00", EMPTY, COUNT, INTR, DATA); else passed++;
        @(negedge CLK);
        RST_N = 1'b1; INT_EN = 1'b0;
        @(negedge CLK);
        push_key(8'h77);
        total++; if (EMPTY !== 1'b0 || INTR !== 1'b0 || DATA !== 8'h77) $display("FAIL int_disabled empty=%b intr=%b data=%h exp=0/0/77", EMPTY, INTR, DATA); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_held_valid();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
